// File: rtl/pcs_tx_scramble_gearbox.sv
// TX PCS stage: x^58 + x^39 + 1 payload scrambler followed by a 66:64 gearbox, one block per cycle.
// Optional: define PCS_SCRAMBLE_BYPASS_EN to add a per-block scrambler bypass input (scr_bypass_i).
`timescale 1ns/1ps
module pcs_tx_scramble_gearbox #(
  parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        tx_clk_i,
  input  logic        tx_rst_n_i,
  input  logic [65:0] in_block_i,
  input  logic        in_valid_i,
`ifdef PCS_SCRAMBLE_BYPASS_EN
  input  logic        scr_bypass_i,
`endif
  output logic        in_ready_o,
  output logic [63:0] out_data_o,
  output logic        out_valid_o,
  output logic        idle_insert_o,
  output logic [5:0]  gb_seq_o
);

  localparam logic [5:0]  SEQ_LAST   = 6'd32;
  localparam logic [6:0]  RES_FULL   = 7'd64;
  localparam logic [65:0] IDLE_BLOCK = {56'h0, 8'h1E, 2'b01};

  typedef enum logic {ST_HALT, ST_RUN} state_e;

  // ---------------------------------------------------------------------------
  // Sequencer: the 33-cycle gearbox frame and the registered upstream ready
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [5:0] seq_q, seq_d;
  logic       ready_q, ready_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    seq_d   = seq_q;
    ready_d = ready_q;
    case (state_q)
      ST_HALT: begin
        state_d = ST_RUN;
        seq_d   = '0;
        ready_d = 1'b1;
      end
      ST_RUN: begin
        seq_d   = (seq_q == SEQ_LAST) ? '0 : seq_q + 6'd1;
        ready_d = (seq_d != SEQ_LAST);
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge tx_clk_i or negedge tx_rst_n_i) begin
    if (!tx_rst_n_i) begin
      state_q <= ST_HALT;
      seq_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
      state_q <= state_d;
      seq_q   <= seq_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Acceptance stage: take the upstream block, or a local idle when none offered
  // ---------------------------------------------------------------------------
  logic [65:0] a_blk_q;
  logic        a_vld_q;
  logic        a_idle_q;
`ifdef PCS_SCRAMBLE_BYPASS_EN
  logic        a_byp_q;
`endif

  always_ff @(posedge tx_clk_i or negedge tx_rst_n_i) begin
    if (!tx_rst_n_i) begin
      // NOTE: datapath registers are reset as well, so a reset discards any half-packed block.
      a_blk_q  <= '0;
      a_vld_q  <= 1'b0;
      a_idle_q <= 1'b0;
`ifdef PCS_SCRAMBLE_BYPASS_EN
      a_byp_q  <= 1'b0;
`endif
    end else begin
      a_vld_q  <= ready_q;
      a_idle_q <= ready_q & ~in_valid_i;
      if (ready_q) begin
        a_blk_q <= in_valid_i ? in_block_i : IDLE_BLOCK;
`ifdef PCS_SCRAMBLE_BYPASS_EN
        a_byp_q <= scr_bypass_i;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scrambler: 64 serial bit-steps unrolled; history holds the last 58 line bits
  // ---------------------------------------------------------------------------
  logic [57:0] scr_q, scr_d, scr_walk;
  logic [63:0] pay_s;
  logic        scr_bit;

  always_comb begin
    scr_walk = scr_q;
    pay_s    = '0;
    scr_bit  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      scr_bit = a_blk_q[i+2] ^ scr_walk[38] ^ scr_walk[57];
`ifdef PCS_SCRAMBLE_BYPASS_EN
      if (a_byp_q) scr_bit = a_blk_q[i+2];
`endif
      pay_s[i] = scr_bit;
      scr_walk = {scr_walk[56:0], scr_bit};
    end
    scr_d = a_vld_q ? scr_walk : scr_q;
  end

  logic [65:0] b_blk_q;
  logic        b_vld_q;
  logic        idle_q;

  always_ff @(posedge tx_clk_i or negedge tx_rst_n_i) begin
    if (!tx_rst_n_i) begin
      scr_q   <= SCR_SEED;
      b_blk_q <= '0;
      b_vld_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      scr_q   <= scr_d;
      b_vld_q <= a_vld_q;
      idle_q  <= a_idle_q;
      if (a_vld_q) b_blk_q <= {pay_s, a_blk_q[1:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Gearbox: residual grows by 2 bits per block; the bubble slot drains all 64
  // ---------------------------------------------------------------------------
  logic [63:0]  res_q, res_d;
  logic [6:0]   res_cnt_q, res_cnt_d;
  logic [127:0] gb_cat;
  logic [63:0]  word_d;
  logic         emit;

  always_comb begin
    gb_cat    = {64'h0, res_q} | ({62'h0, b_blk_q} << res_cnt_q);
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    word_d    = '0;
    emit      = 1'b0;
    if (b_vld_q) begin
      emit      = 1'b1;
      word_d    = gb_cat[63:0];
      res_d     = gb_cat[127:64];
      res_cnt_d = res_cnt_q + 7'd2;
    end else if (res_cnt_q == RES_FULL) begin
      emit      = 1'b1;
      word_d    = res_q;
      res_d     = '0;
      res_cnt_d = '0;
    end
  end

  logic [63:0] out_data_q;
  logic        out_valid_q;

  always_ff @(posedge tx_clk_i or negedge tx_rst_n_i) begin
    if (!tx_rst_n_i) begin
      res_q       <= '0;
      res_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
      if (emit) begin
        out_data_q  <= word_d;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign in_ready_o    = ready_q;
  assign gb_seq_o      = seq_q;
  assign idle_insert_o = idle_q;
  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;

endmodule
